// File: rtl/conv33_pkg.sv
// conv33_pkg
//   Shared definitions for the 3x3 window generator.
//   - TAP_* : window tap indices, row-major, 0 = top-left, 8 = bottom-right (newest pixel)
//   - NUM_TAPS : number of taps in a 3x3 window
//   - cnt_w() : counter width needed to index 0..n-1 (never less than 1 bit)
package conv33_pkg;

  localparam int NUM_TAPS = 9;

  localparam int TAP_TL = 0;
  localparam int TAP_TM = 1;
  localparam int TAP_TR = 2;
  localparam int TAP_ML = 3;
  localparam int TAP_MM = 4;
  localparam int TAP_MR = 5;
  localparam int TAP_BL = 6;
  localparam int TAP_BM = 7;
  localparam int TAP_BR = 8;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv33_line_buf.sv
// conv33_line_buf
//   Two-row line buffer packed into one word per column:
//   word[2*DATA_W-1:DATA_W] = row r-2, word[DATA_W-1:0] = row r-1.
//   Asynchronous read so the old contents are available in the same cycle
//   as the write (read-before-write). Contents are not reset; the window
//   generator never emits a window built from rows that were not written
//   in the current frame.
// Ports
//   clk      in   rising-edge clock
//   we       in   write enable
//   addr     in   column address (shared by read and write)
//   wr_data  in   new word {row r-1, row r}
//   rd_data  out  current word at addr
module conv33_line_buf
  import conv33_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = cnt_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [2*DATA_W-1:0]   wr_data,
  output logic [2*DATA_W-1:0]   rd_data
);

  logic [2*DATA_W-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/conv33_window_gen.sv
// conv33_window_gen
//   Streaming 3x3 window generator. Takes a raster-order pixel stream,
//   buffers two rows and emits every full 3x3 window (no border windows)
//   over a valid/ready interface with a single output register.
// Ports
//   clk, rst_n               clock, synchronous active-low reset
//   s_valid/s_ready/s_data   pixel input stream
//   m_valid/m_ready          window output handshake
//   m_win_0..m_win_8         window taps, 0 = top-left, 8 = bottom-right
//   frame_done               1-cycle pulse after the last pixel of a frame
// Optional (macro CONV33_KERNEL_LOAD_EN):
//   k_valid/k_data           kernel coefficient load stream
//   kernel_0..kernel_8       loaded coefficients
//   k_loaded                 all nine coefficients written
module conv33_window_gen
  import conv33_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_win_0,
  output logic [DATA_W-1:0] m_win_1,
  output logic [DATA_W-1:0] m_win_2,
  output logic [DATA_W-1:0] m_win_3,
  output logic [DATA_W-1:0] m_win_4,
  output logic [DATA_W-1:0] m_win_5,
  output logic [DATA_W-1:0] m_win_6,
  output logic [DATA_W-1:0] m_win_7,
  output logic [DATA_W-1:0] m_win_8,
  output logic              frame_done
`ifdef CONV33_KERNEL_LOAD_EN
  ,
  input  logic              k_valid,
  input  logic [DATA_W-1:0] k_data,
  output logic [DATA_W-1:0] kernel_0,
  output logic [DATA_W-1:0] kernel_1,
  output logic [DATA_W-1:0] kernel_2,
  output logic [DATA_W-1:0] kernel_3,
  output logic [DATA_W-1:0] kernel_4,
  output logic [DATA_W-1:0] kernel_5,
  output logic [DATA_W-1:0] kernel_6,
  output logic [DATA_W-1:0] kernel_7,
  output logic [DATA_W-1:0] kernel_8,
  output logic              k_loaded
`endif
);

  localparam int COL_W = cnt_w(IMG_W);
  localparam int ROW_W = cnt_w(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  logic [COL_W-1:0]    col_reg;
  logic [ROW_W-1:0]    row_reg;
  logic                m_valid_reg;
  logic                frame_done_reg;
  logic                accept;
  logic [2*DATA_W-1:0] lb_rd;
  logic [2*DATA_W-1:0] lb_wr;
  logic [DATA_W-1:0]   col_in [3];
  logic [DATA_W-1:0]   win_tap [NUM_TAPS];

  // Single output register: a new pixel may enter only when the current
  // window is absent or leaving this cycle.
  assign s_ready = !m_valid_reg || m_ready;
  assign accept  = s_valid && s_ready;

  // Row r-1 moves down to the r-2 slot, the new pixel becomes row r-1.
  assign lb_wr = {lb_rd[DATA_W-1:0], s_data};

  // New right-hand window column, top to bottom.
  assign col_in[0] = lb_rd[2*DATA_W-1:DATA_W];
  assign col_in[1] = lb_rd[DATA_W-1:0];
  assign col_in[2] = s_data;

  conv33_line_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (IMG_W),
    .ADDR_W (COL_W)
  ) u_line_buf (
    .clk     (clk),
    .we      (accept),
    .addr    (col_reg),
    .wr_data (lb_wr),
    .rd_data (lb_rd)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_reg        <= '0;
      row_reg        <= '0;
      m_valid_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= accept && (col_reg == COL_LAST) && (row_reg == ROW_LAST);
      if (accept) begin
        // Only windows fully inside the frame are emitted.
        m_valid_reg <= (row_reg >= ROW_TWO) && (col_reg >= COL_TWO);
        if (col_reg == COL_LAST) begin
          col_reg <= '0;
          row_reg <= (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
        end else begin
          col_reg <= col_reg + 1'b1;
        end
      end else if (m_ready) begin
        m_valid_reg <= 1'b0;
      end
    end
  end

  // One 3-tap shift register per window row; shifts only on accept, so a
  // stalled window stays frozen.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_row
      logic [DATA_W-1:0] tap_reg [3];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          tap_reg[0] <= '0;
          tap_reg[1] <= '0;
          tap_reg[2] <= '0;
        end else if (accept) begin
          tap_reg[0] <= tap_reg[1];
          tap_reg[1] <= tap_reg[2];
          tap_reg[2] <= col_in[gi];
        end
      end

      assign win_tap[3*gi + 0] = tap_reg[0];
      assign win_tap[3*gi + 1] = tap_reg[1];
      assign win_tap[3*gi + 2] = tap_reg[2];
    end
  endgenerate

  assign m_valid    = m_valid_reg;
  assign frame_done = frame_done_reg;
  assign m_win_0    = win_tap[TAP_TL];
  assign m_win_1    = win_tap[TAP_TM];
  assign m_win_2    = win_tap[TAP_TR];
  assign m_win_3    = win_tap[TAP_ML];
  assign m_win_4    = win_tap[TAP_MM];
  assign m_win_5    = win_tap[TAP_MR];
  assign m_win_6    = win_tap[TAP_BL];
  assign m_win_7    = win_tap[TAP_BM];
  assign m_win_8    = win_tap[TAP_BR];

`ifdef CONV33_KERNEL_LOAD_EN
  logic [3:0]        k_idx_reg;
  logic              k_loaded_reg;
  logic [DATA_W-1:0] kern_tap [NUM_TAPS];

  // A write while loaded lands on index 0 (idx wrapped) and clears the
  // loaded flag, which restarts the load sequence.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_idx_reg    <= '0;
      k_loaded_reg <= 1'b0;
    end else if (k_valid) begin
      if (k_idx_reg == 4'd8) begin
        k_idx_reg    <= '0;
        k_loaded_reg <= 1'b1;
      end else begin
        k_idx_reg    <= k_idx_reg + 1'b1;
        k_loaded_reg <= 1'b0;
      end
    end
  end

  generate
    for (gi = 0; gi < NUM_TAPS; gi++) begin : g_kern
      logic [DATA_W-1:0] kern_reg;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          kern_reg <= '0;
        end else if (k_valid && (k_idx_reg == 4'(gi))) begin
          kern_reg <= k_data;
        end
      end

      assign kern_tap[gi] = kern_reg;
    end
  endgenerate

  assign kernel_0 = kern_tap[0];
  assign kernel_1 = kern_tap[1];
  assign kernel_2 = kern_tap[2];
  assign kernel_3 = kern_tap[3];
  assign kernel_4 = kern_tap[4];
  assign kernel_5 = kern_tap[5];
  assign kernel_6 = kern_tap[6];
  assign kernel_7 = kern_tap[7];
  assign kernel_8 = kern_tap[8];
  assign k_loaded = k_loaded_reg;
`endif

endmodule

// File: tb/tb_conv33_window_gen.sv
// Testbench for conv33_window_gen on a 4x4 image. Expected windows are
// computed from a frame image model and queued when a pixel is accepted;
// a monitor pops and compares each window as it is handed downstream.
module tb_conv33_window_gen;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;

  typedef logic [8:0][DW-1:0] win_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_win_0, m_win_1, m_win_2, m_win_3, m_win_4;
  logic [DW-1:0] m_win_5, m_win_6, m_win_7, m_win_8;
  logic          frame_done;
`ifdef CONV33_KERNEL_LOAD_EN
  logic          k_valid;
  logic [DW-1:0] k_data;
  logic [DW-1:0] kernel_0, kernel_1, kernel_2, kernel_3, kernel_4;
  logic [DW-1:0] kernel_5, kernel_6, kernel_7, kernel_8;
  logic          k_loaded;
`endif

  always #5 clk = ~clk;

  conv33_window_gen #(
    .DATA_W (DW),
    .IMG_W  (W),
    .IMG_H  (H)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_win_0    (m_win_0),
    .m_win_1    (m_win_1),
    .m_win_2    (m_win_2),
    .m_win_3    (m_win_3),
    .m_win_4    (m_win_4),
    .m_win_5    (m_win_5),
    .m_win_6    (m_win_6),
    .m_win_7    (m_win_7),
    .m_win_8    (m_win_8),
    .frame_done (frame_done)
`ifdef CONV33_KERNEL_LOAD_EN
    ,
    .k_valid    (k_valid),
    .k_data     (k_data),
    .kernel_0   (kernel_0),
    .kernel_1   (kernel_1),
    .kernel_2   (kernel_2),
    .kernel_3   (kernel_3),
    .kernel_4   (kernel_4),
    .kernel_5   (kernel_5),
    .kernel_6   (kernel_6),
    .kernel_7   (kernel_7),
    .kernel_8   (kernel_8),
    .k_loaded   (k_loaded)
`endif
  );

  win_t act;
  assign act = {m_win_8, m_win_7, m_win_6, m_win_5, m_win_4,
                m_win_3, m_win_2, m_win_1, m_win_0};

  int   checks = 0;
  int   errors = 0;
  int   n_win  = 0;
  win_t exp_q [$];
  win_t mon_exp;
  win_t held;

  logic [DW-1:0] img [H][W];
  int mcol = 0;
  int mrow = 0;

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Model: store the pixel in the frame image and, for interior positions,
  // queue the window whose bottom-right pixel it is.
  task automatic model_accept(input logic [DW-1:0] d, output bit win_now, output bit last);
    win_t w;
    img[mrow][mcol] = d;
    win_now = (mrow >= 2) && (mcol >= 2);
    last    = (mcol == W - 1) && (mrow == H - 1);
    if (win_now) begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          w[3*r + c] = img[mrow - 2 + r][mcol - 2 + c];
      exp_q.push_back(w);
    end
    if (mcol == W - 1) begin
      mcol = 0;
      mrow = (mrow == H - 1) ? 0 : mrow + 1;
    end else begin
      mcol++;
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [DW-1:0] d);
    int n;
    bit win_now, last;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    @(negedge clk);
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("s_ready_timeout", s_ready, 1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    model_accept(d, win_now, last);
    check("frame_done", frame_done, last);
    if (m_ready) begin
      check("m_valid_latency", m_valid, win_now);
      if (win_now) check("win_latency", act, exp_q[$]);
    end
  endtask

  task automatic send_frame(input int base, input bit gap);
    for (int i = 0; i < W * H; i++) begin
      send(DW'(base + i));
      if (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic drain(input string tag);
    repeat (3) @(negedge clk);
    check(tag, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Window handed downstream whenever valid and ready are both high.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_window", act, 0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("window", act, mon_exp);
        $display("window %0d: taps0..8 = %0d %0d %0d %0d %0d %0d %0d %0d %0d", n_win,
                 m_win_0, m_win_1, m_win_2, m_win_3, m_win_4, m_win_5, m_win_6, m_win_7, m_win_8);
        n_win++;
      end
    end
  end

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b1;
`ifdef CONV33_KERNEL_LOAD_EN
    k_valid = 1'b0;
    k_data  = '0;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset_m_valid", m_valid, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_win", act, 0);
    check("reset_s_ready", s_ready, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: single frame, downstream always ready
    send_frame(0, 1'b0);
    drain("t1_all_windows");

    // 2: downstream stalls 5 cycles on the first window
    for (int i = 0; i <= 10; i++) send(DW'(i));
    m_ready = 1'b0;
    held    = act;
    check("t2_first_window", held, exp_q[0]);
    s_valid = 1'b1;
    s_data  = DW'(11);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_hold_s_ready", s_ready, 0);
      check("t2_hold_m_valid", m_valid, 1);
      check("t2_hold_win", act, held);
    end
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    for (int i = 11; i < 16; i++) send(DW'(i));
    drain("t2_all_windows");

    // 3: back-to-back frames
    send_frame(0, 1'b0);
    send_frame(100, 1'b0);
    drain("t3_all_windows");

    // 4: reset mid-frame after pixel 9, then a full frame
    for (int i = 0; i <= 9; i++) send(DW'(i));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    mcol = 0;
    mrow = 0;
    check("t4_m_valid_after_reset", m_valid, 0);
    check("t4_win_after_reset", act, 0);
    send_frame(0, 1'b0);
    drain("t4_all_windows");

    // 5: input valid every other cycle
    send_frame(0, 1'b1);
    drain("t5_all_windows");
    check("total_windows", n_win, 4 + 4 + 8 + 4 + 4);

`ifdef CONV33_KERNEL_LOAD_EN
    // 6: kernel load, then restart
    for (int i = 1; i <= 9; i++) begin
      k_valid = 1'b1;
      k_data  = DW'(i);
      @(posedge clk);
      #1;
      k_valid = 1'b0;
    end
    check("k_loaded_set", k_loaded, 1);
    check("kernels", {kernel_8, kernel_7, kernel_6, kernel_5, kernel_4,
                      kernel_3, kernel_2, kernel_1, kernel_0},
          {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
    k_valid = 1'b1;
    k_data  = 8'd42;
    @(posedge clk);
    #1;
    k_valid = 1'b0;
    check("k_restart_kernel_0", kernel_0, 42);
    check("k_restart_kernel_1", kernel_1, 2);
    check("k_loaded_cleared", k_loaded, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
